// File: rtl/mem_pkg.sv
// Shared encodings for the mem_access_v2 MEM stage: branch codes, access sizes,
// memory read/write encodings and the handshake FSM state type.
package mem_pkg;

  localparam logic [2:0] MEMB_NONE = 3'd0;
  localparam logic [2:0] MEMB_BEQ  = 3'd1;
  localparam logic [2:0] MEMB_BNE  = 3'd2;
  localparam logic [2:0] MEMB_BLT  = 3'd3;
  localparam logic [2:0] MEMB_BGE  = 3'd4;
  localparam logic [2:0] MEMB_BLTU = 3'd5;
  localparam logic [2:0] MEMB_BGEU = 3'd6;
  // Both unconditional jumps redirect identically here, so they share a code.
  localparam logic [2:0] MEMB_JAL  = 3'd7;
  localparam logic [2:0] MEMB_JALR = 3'd7;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] MEMRW_NONE  = 2'b00;
  localparam logic [1:0] MEMRW_WRITE = 2'b01;
  localparam logic [1:0] MEMRW_READ  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_RD = 2'd1,
    ST_WAIT_WR = 2'd2,
    ST_DONE    = 2'd3
  } mem_state_e;

  // alu_zero / alu_one come from the EX result (compare difference or slt output).
  function automatic logic branch_hit(input logic [2:0] code, input logic alu_zero,
                                      input logic alu_one);
    logic hit;
    hit = 1'b0;
    case (code)
      MEMB_NONE:                     hit = 1'b0;
      MEMB_BEQ, MEMB_BGE, MEMB_BGEU: hit = alu_zero;
      MEMB_BNE:                      hit = !alu_zero;
      MEMB_BLT, MEMB_BLTU:           hit = alu_one;
      default:                       hit = (code == MEMB_JAL) || (code == MEMB_JALR);
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the MEM stage: store lane replication and byte enables,
// load lane extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]                funct3,
  input  logic [$clog2(XLEN/8)-1:0] lane,
  input  logic [XLEN-1:0]           store_data,
  input  logic [XLEN-1:0]           load_raw,
  output logic [XLEN-1:0]           store_lanes_c,
  output logic [XLEN/8-1:0]         be_c,
  output logic [XLEN-1:0]           load_ext_c
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned MW = 2 * NB;

  int unsigned            nbytes;
  int unsigned            pad;
  logic [MW-1:0]          mask;
  logic [XLEN-1:0]        shifted;
  logic [XLEN-1:0]        top;
  logic signed [XLEN-1:0] sext;

  // Access size in bytes; a doubleword on a 32-bit datapath collapses to a word.
  always_comb begin
    case (funct3[1:0])
      SZ_B:    nbytes = 1;
      SZ_H:    nbytes = 2;
      SZ_W:    nbytes = 4;
      default: nbytes = 8;
    endcase
    if (nbytes > NB) nbytes = NB;
    pad = XLEN - 8 * nbytes;
  end

  // Lanes shifted past the top byte are simply dropped.
  always_comb begin
    mask = MW'((32'd1 << nbytes) - 32'd1);
    be_c = NB'(mask << lane);
  end

  always_comb begin
    store_lanes_c = '0;
    for (int i = 0; i < NB; i++) begin
      store_lanes_c[i*8 +: 8] = store_data[(unsigned'(i) % nbytes) * 8 +: 8];
    end
  end

  // Left-justify the field, then shift back arithmetically or logically.
  always_comb begin
    shifted    = load_raw >> {lane, 3'b000};
    top        = shifted << pad;
    sext       = $signed(top) >>> pad;
    load_ext_c = funct3[2] ? (top >> pad) : $unsigned(sext);
  end

endmodule

// File: rtl/mem_access_v2.sv
// MEM stage between EX/MEM and MEM/WB: data memory handshake FSM, sub-word access,
// branch resolution. Optional MEM_MISALIGN_TRAP_EN blocks misaligned accesses.
module mem_access_v2
  import mem_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5,
  parameter int unsigned NBR  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              keep,
  input  logic              nop,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic [1:0]        ex_memtoreg,
  input  logic [1:0]        ex_memrw,
  input  logic [2:0]        ex_funct3,
  input  logic [NBR-1:0]    ex_branch,
  input  logic [XLEN-1:0]   ex_alu,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [XLEN-1:0]   ex_pc_branch,
  input  logic [XLEN-1:0]   ex_pcp4,
  input  logic [REGW-1:0]   ex_wreg,
  input  logic [31:0]       ex_instr,
  output logic [XLEN-1:0]   daddr,
  output logic              dreq,
  output logic              dwrite,
  output logic [XLEN/8-1:0] dbe,
  inout  logic [XLEN-1:0]   ddata,
  input  logic              dready_n,
  input  logic              dbusy,
  output logic              mem_stall,
  output logic              wb_regwrite,
  output logic [1:0]        wb_memtoreg,
  output logic [REGW-1:0]   wb_wreg,
  output logic [XLEN-1:0]   wb_alu,
  output logic [XLEN-1:0]   wb_pcp4,
  output logic [31:0]       wb_instr,
  output logic [XLEN-1:0]   wb_load_data,
  output logic [XLEN-1:0]   branch_pc,
  output logic              branch_taken,
  output logic              branch_flush
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o,
  output logic [XLEN-1:0]   misalign_addr_o
`endif
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LB = $clog2(NB);

  mem_state_e      state, state_nx;
  logic            kill;
  logic [XLEN-1:0] hold_data;
  logic [XLEN-1:0] st_lanes_c, ld_ext_c;
  logic [NB-1:0]   be_c;
  logic [LB-1:0]   lane_c;
  logic            is_rd_c, is_wr_c, misal_c, mem_op_c, start_c, taken_c;
  logic            adv_c, cap_c, use_hold_c;

  assign lane_c  = ex_alu[LB-1:0];
  assign is_rd_c = (ex_memrw & MEMRW_READ) != MEMRW_NONE;
  assign is_wr_c = ex_memrw == MEMRW_WRITE;

`ifdef MEM_MISALIGN_TRAP_EN
  logic [LB-1:0] align_m_c;
  always_comb begin
    case (ex_funct3[1:0])
      SZ_B:    align_m_c = '0;
      SZ_H:    align_m_c = LB'(1);
      SZ_W:    align_m_c = LB'(3);
      default: align_m_c = LB'(7);
    endcase
  end
  assign misal_c = ex_valid && (ex_memrw != MEMRW_NONE) && ((lane_c & align_m_c) != '0);
`else
  assign misal_c = 1'b0;
`endif

  assign mem_op_c = ex_valid && (ex_memrw != MEMRW_NONE) && !misal_c;
  assign start_c  = (state == ST_IDLE) && mem_op_c && !keep;
  assign taken_c  = ex_valid && branch_hit(3'(ex_branch), ex_alu == '0, ex_alu == XLEN'(1));

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .funct3        (ex_funct3),
    .lane          (lane_c),
    .store_data    (ex_store_data),
    .load_raw      (ddata),
    .store_lanes_c (st_lanes_c),
    .be_c          (be_c),
    .load_ext_c    (ld_ext_c)
  );

  assign daddr = {ex_alu[XLEN-1:LB], LB'(0)};
  assign dbe   = dreq ? be_c : '0;
  assign ddata = (dreq && dwrite) ? st_lanes_c : {XLEN{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Handshake FSM; adv_c marks the edge where the MEM/WB payload advances.
  always_comb begin
    state_nx   = state;
    dreq       = 1'b0;
    dwrite     = 1'b0;
    mem_stall  = 1'b0;
    adv_c      = 1'b0;
    cap_c      = 1'b0;
    use_hold_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_c) begin
          dreq   = 1'b1;
          dwrite = is_wr_c;
          if (dbusy) begin
            mem_stall = 1'b1;
          end else if (is_rd_c) begin
            state_nx  = ST_WAIT_RD;
            mem_stall = 1'b1;
          end else if (!dready_n) begin
            adv_c = 1'b1;
          end else begin
            state_nx  = ST_WAIT_WR;
            mem_stall = 1'b1;
          end
        end else if (!keep) begin
          adv_c = 1'b1;
        end
      end
      ST_WAIT_RD, ST_WAIT_WR: begin
        dreq   = 1'b1;
        dwrite = (state == ST_WAIT_WR);
        if (dready_n) begin
          mem_stall = 1'b1;
        end else if (keep) begin
          state_nx  = ST_DONE;
          cap_c     = 1'b1;
          mem_stall = 1'b1;
        end else begin
          state_nx = ST_IDLE;
          adv_c    = 1'b1;
        end
      end
      ST_DONE: begin
        if (keep) begin
          mem_stall = 1'b1;
        end else begin
          state_nx   = ST_IDLE;
          adv_c      = 1'b1;
          use_hold_c = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A flush during an outstanding access discards its result when it completes.
  always_ff @(posedge clk) begin
    if (rst)                        kill <= 1'b0;
    else if (state_nx == ST_IDLE)   kill <= 1'b0;
    else if (nop)                   kill <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)        hold_data <= '0;
    else if (cap_c) hold_data <= ld_ext_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_regwrite     <= 1'b0;
      wb_memtoreg     <= '0;
      wb_wreg         <= '0;
      wb_alu          <= '0;
      wb_pcp4         <= '0;
      wb_instr        <= '0;
      wb_load_data    <= '0;
      branch_pc       <= '0;
      branch_taken    <= 1'b0;
      branch_flush    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
`endif
    end else if (nop || (adv_c && kill)) begin
      wb_regwrite     <= 1'b0;
      wb_memtoreg     <= '0;
      wb_wreg         <= '0;
      wb_alu          <= '0;
      branch_pc       <= '0;
      branch_taken    <= 1'b0;
      branch_flush    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
`endif
    end else if (adv_c) begin
      wb_regwrite     <= ex_valid && ex_regwrite && !misal_c;
      wb_memtoreg     <= ex_memtoreg;
      wb_wreg         <= ex_wreg;
      wb_alu          <= ex_alu;
      wb_pcp4         <= ex_pcp4;
      wb_instr        <= ex_instr;
      wb_load_data    <= (mem_op_c && is_rd_c) ? (use_hold_c ? hold_data : ld_ext_c) : '0;
      branch_pc       <= taken_c ? ex_pc_branch : '0;
      branch_taken    <= taken_c;
      branch_flush    <= taken_c;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o      <= misal_c;
      misalign_addr_o <= misal_c ? ex_alu : '0;
`endif
    end else begin
      branch_taken    <= 1'b0;
      branch_flush    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o      <= 1'b0;
`endif
    end
  end

endmodule
